// File: rtl/nl_lut_loader_pkg.sv
// Shared sizing, state encoding and LUT layout for the nonlinear LUT loader.
package nl_lut_loader_pkg;

  localparam int LUT_ADDR       = 7;
  localparam int LUT_SIZE       = 128;
  localparam int LUT_DATA_WIDTH = 8;
  localparam int N_DIM_ARRAY    = 4;
  localparam int MEM_ADDR_SIZE  = 16;

  localparam int MEM_DATA_WIDTH = N_DIM_ARRAY * LUT_DATA_WIDTH;
  localparam int LANE_W         = (N_DIM_ARRAY > 1) ? $clog2(N_DIM_ARRAY) : 1;

  // Entry count as seen on num_entries (one bit wider than the LUT address).
  localparam logic [LUT_ADDR:0] LUT_SIZE_C = (LUT_ADDR + 1)'(LUT_SIZE);

  // LUT layout: sigmoid PWL block, its shift/limits, then the tanh equivalents.
  localparam int SIG_BASE        = 0;
  localparam int SIG_PARAM_BASE  = 48;
  localparam int SIG_PARAM_LAST  = 52;
  localparam int TANH_BASE       = 53;
  localparam int TANH_PARAM_BASE = 101;
  localparam int TANH_PARAM_LAST = 105;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_WAIT  = 3'd2,
    S_EMIT  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  // Requests larger than the LUT are cut down to a full-LUT load.
  function automatic logic [LUT_ADDR:0] clamp_count(input logic [LUT_ADDR:0] n);
    return (n > LUT_SIZE_C) ? LUT_SIZE_C : n;
  endfunction

endpackage

// File: rtl/nl_lut_loader.sv
// Streams packed LUT entries from config memory into the nonlinear LUT write port.
//
// Handshake: start is a one-cycle request with no ready; it is accepted only in
// IDLE and ignored otherwise. Memory reads have no backpressure: mem_rd_data is
// valid exactly one cycle after mem_rd_en. The LUT write port is a plain strobe
// (wr_en_ext_lut) with address/data valid in the same cycle.
module nl_lut_loader
  import nl_lut_loader_pkg::*;
(
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [MEM_ADDR_SIZE-1:0]  base_addr,
  input  logic [LUT_ADDR:0]         num_entries,
  output logic                      mem_rd_en,
  output logic [MEM_ADDR_SIZE-1:0]  mem_rd_addr,
  input  logic [MEM_DATA_WIDTH-1:0] mem_rd_data,
  output logic                      wr_en_ext_lut,
  output logic [LUT_ADDR-1:0]       wr_addr_ext_lut,
  output logic [LUT_DATA_WIDTH-1:0] wr_data_ext_lut,
  output logic                      busy,
  output logic                      done,
  output logic                      err,
  output state_t                    state_dbg
);

  localparam logic [LANE_W-1:0] LANE_LAST = LANE_W'(N_DIM_ARRAY - 1);
  localparam logic [LUT_ADDR:0] CNT_ONE   = (LUT_ADDR + 1)'(1);

  state_t                    state_q, state_d;
  logic [MEM_ADDR_SIZE-1:0]  word_addr_q;
  logic [LUT_ADDR:0]         remaining_q;
  logic [LUT_ADDR-1:0]       lut_cnt_q;
  logic [LANE_W-1:0]         lane_q;
  logic [MEM_DATA_WIDTH-1:0] data_q;
  logic                      err_q;

  logic [LUT_ADDR:0] start_cnt;
  logic [LUT_ADDR:0] remaining_after;
  logic              last_lane;

  assign start_cnt       = clamp_count(num_entries);
  assign remaining_after = remaining_q - CNT_ONE;
  assign last_lane       = (lane_q == LANE_LAST);

  // Next-state decode; a word ends early when the remaining count runs out.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = (start_cnt == '0) ? S_DONE : S_FETCH;
      S_FETCH: state_d = S_WAIT;
      S_WAIT:  state_d = S_EMIT;
      S_EMIT: begin
        if (remaining_after == '0) state_d = S_DONE;
        else if (last_lane)        state_d = S_FETCH;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State register plus address/count/data bookkeeping per state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      word_addr_q <= '0;
      remaining_q <= '0;
      lut_cnt_q   <= '0;
      lane_q      <= '0;
      data_q      <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            word_addr_q <= base_addr;
            remaining_q <= start_cnt;
            lut_cnt_q   <= '0;
            lane_q      <= '0;
            err_q       <= (num_entries > LUT_SIZE_C);
          end
        end
        S_WAIT: begin
          data_q      <= mem_rd_data;
          word_addr_q <= word_addr_q + MEM_ADDR_SIZE'(1);
          lane_q      <= '0;
        end
        S_EMIT: begin
          lut_cnt_q   <= lut_cnt_q + LUT_ADDR'(1);
          lane_q      <= lane_q + LANE_W'(1);
          remaining_q <= remaining_after;
        end
        default: ;
      endcase
    end
  end

  // Outputs come only from registered state so idle ports read as zero.
  always_comb begin
    mem_rd_en       = (state_q == S_FETCH);
    mem_rd_addr     = mem_rd_en ? word_addr_q : '0;
    wr_en_ext_lut   = (state_q == S_EMIT);
    wr_addr_ext_lut = wr_en_ext_lut ? lut_cnt_q : '0;
    wr_data_ext_lut = wr_en_ext_lut ? data_q[lane_q * LUT_DATA_WIDTH +: LUT_DATA_WIDTH] : '0;
    busy            = (state_q != S_IDLE);
    done            = (state_q == S_DONE);
    err             = err_q;
    state_dbg       = state_q;
  end

endmodule

// File: doc/nl_lut_loader.md
Name: nl_lut_loader

Overview:
- Fills the nonlinear-function LUT (sigmoid/tanh PWL coefficients, shift, clamp limits) from a parameter region of activation/config memory.
- Drives the LUT external write port (wr_en_ext_lut / wr_addr_ext_lut / wr_data_ext_lut) that the nonlinear block consumes.
- Started by the controller before any sigmoid/tanh layer; signals done when the LUT is consistent.

Parameters:
- LUT_ADDR, 7, LUT address width.
- LUT_SIZE, 128, number of LUT entries; must be <= 2^LUT_ADDR.
- LUT_DATA_WIDTH, 8, width of one LUT entry.
- N_DIM_ARRAY, 4, number of LUT entries packed per memory word.
- MEM_ADDR_SIZE, 16, memory word-address width.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle load request; ignored while busy
- base_addr  in  MEM_ADDR_SIZE  word address of the first packed word; sampled on start
- num_entries  in  LUT_ADDR+1  entries to load; sampled on start
- mem_rd_en  out  1  memory read request
- mem_rd_addr  out  MEM_ADDR_SIZE  memory read address
- mem_rd_data  in  N_DIM_ARRAY*LUT_DATA_WIDTH  read data, valid the cycle after mem_rd_en; lane k = bits [(k+1)*W-1 : k*W]
- wr_en_ext_lut  out  1  LUT write strobe
- wr_addr_ext_lut  out  LUT_ADDR  LUT write address
- wr_data_ext_lut  out  LUT_DATA_WIDTH  LUT write data (signed)
- busy  out  1  high from the cycle after start until done (inclusive)
- done  out  1  one-cycle completion pulse
- err  out  1  sticky clamp flag; cleared on the next accepted start

Behaviour:
- Reset: state IDLE. All outputs are 0: mem_rd_en, mem_rd_addr, wr_en_ext_lut, wr_addr_ext_lut, wr_data_ext_lut, busy, done, err. Counters and the data register are 0.
- Outputs are decoded from registered state and counters only; there is no combinational input-to-output path.
- IDLE: start=1 latches base_addr and num_entries, clears err and the LUT address counter.
  - If the effective count is 0, go to DONE.
  - Otherwise go to FETCH.
- Effective count: if num_entries > LUT_SIZE, clamp to LUT_SIZE and set err.
- FETCH (1 cycle): mem_rd_en=1, mem_rd_addr = current word address; go to WAIT.
- WAIT (1 cycle): register mem_rd_data at the end of the cycle; increment the word address modulo 2^MEM_ADDR_SIZE (MAX wraps to 0); go to EMIT.
- EMIT: one write per cycle, lane 0 first.
  - wr_en_ext_lut=1, wr_addr_ext_lut = LUT counter, wr_data_ext_lut = current lane.
  - LUT counter and lane index increment each cycle.
  - When the last lane is written or the remaining count reaches 0: go to FETCH if entries remain, else DONE.
- Partial last word: only the remaining lanes are written; upper lanes are discarded.
- DONE (1 cycle): done=1; go to IDLE. busy=1 in FETCH, WAIT, EMIT and DONE.
- Timing: with start sampled at edge 0, the first FETCH is cycle 1. Each full word costs 2+N_DIM_ARRAY cycles, and DONE follows the last EMIT.
- start while not IDLE: ignored; no relatch, err unchanged.
- reset mid-operation: next cycle is IDLE with all outputs 0. Partial LUT contents are not rolled back; the controller must reload.
- mem_rd_en is never high in two consecutive cycles. wr_en_ext_lut is never high in FETCH or WAIT.

Decomposition:
- Shared parameters package: LUT_ADDR, LUT_SIZE, LUT_DATA_WIDTH, N_DIM_ARRAY, and the state enum {IDLE, FETCH, WAIT, EMIT, DONE}.
- Add LUT layout offset constants to the package for software and TB use: sigmoid block at 0, sigmoid shift/limits at 48..52, tanh block from 53, tanh shift/limits at 101..105.
- Single module; no sub-module. Lane select is an indexed part-select.

Test Plan:
- Basic load: W=8, N=4, base=0x10, mem[0x10]=0x04030201, mem[0x11]=0x08070605, num_entries=8, start at edge 0.
  - mem_rd_en in cycles 1 and 7.
  - Writes addr 0..7, data 1..8, in cycles 3-6 and 9-12.
  - done in cycle 13; busy high in cycles 1-13.
- Partial word: num_entries=6, same memory. Exactly 6 writes; the second word writes only addr 4,5 = 5,6; done in cycle 11.
- Empty: num_entries=0. No mem_rd_en, no writes; done=1 and busy=1 in cycle 1; IDLE in cycle 2.
- Clamp: num_entries=200. Exactly 128 writes (addr 0..127) and 32 reads. err=1 from cycle 1, held after done, cleared by the next valid start.
- Reset mid-EMIT: assert reset for 1 cycle during the 3rd write. Next cycle all outputs are 0. A new start with num_entries=4 produces writes at addr 0..3.
- Interference and wrap: base_addr=0xFFFF, num_entries=8, second start pulsed while busy. Reads go to 0xFFFF then 0x0000; the second start has no effect; exactly 8 writes and one done pulse.
